mem_stage_lsu: RTL and testbench

Memory-stage load/store unit of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns each load or store in the M stage into a request/acknowledge transaction on the data-memory port, and generates byte enables and store-data lane placement. It sign- or zero-extends load data into `read_data_m_o`, which feeds the MEM/WB register's `read_data_m_i`, and stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_stage_lsu.sv | 148 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Purpose: M-stage load/store unit; turns loads/stores into req/ack data-memory transactions.
// Latency: request one cycle after the access is presented; load data registered the cycle after ack.
// Backpressure: stall_m_o holds the pipeline from access issue until ack; misaligned accesses never stall.
// Optional: LSU_MISALIGN_CHECK_EN enables misaligned half/word detection and suppression.
module mem_stage_lsu #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read_m_i,
  input  logic                     mem_write_m_i,
  input  logic [2:0]               funct3_m_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]    write_data_m_i,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  output logic [3:0]               dmem_be_o,
  input  logic                     dmem_ack_i,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
  output logic [DATA_WIDTH-1:0]    read_data_m_o,
  output logic                     stall_m_o,
  output logic                     misaligned_m_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_q, state_d;

  logic       access;
  logic       start;
  logic [1:0] size;
  logic [1:0] addr_lo;
  logic [3:0] be_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Captured load type and lane for the outstanding transaction
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [1:0] lo_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [DATA_WIDTH-1:0] load_ext;

  assign access  = mem_read_m_i | mem_write_m_i;
  assign addr_lo = alu_result_m_i[1:0];
  // Size encoding 11 has no RV32I meaning; treat it as a full word
  assign size    = (funct3_m_i[1:0] == 2'b11) ? 2'b10 : funct3_m_i[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned_m_o = access &
                          (((size == 2'b01) & addr_lo[0]) |
                           ((size == 2'b10) & (addr_lo != 2'b00)));
`else
  assign misaligned_m_o = 1'b0;
`endif

  assign start     = (state_q == IDLE) & access & ~misaligned_m_o;
  assign stall_m_o = start | (state_q == REQ);

  // Byte enables and lane-replicated store data for the presented access
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = write_data_m_i;
    case (size)
      2'b00: begin
        be_d    = 4'b0001 << addr_lo;
        wdata_d = {4{write_data_m_i[7:0]}};
      end
      2'b01: begin
        be_d    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{write_data_m_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = write_data_m_i;
      end
    endcase
  end

  // Next-state logic for the transaction sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (dmem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request outputs: captured at issue, held through REQ, request dropped on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_be_o    <= 4'b0000;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      lo_q         <= 2'b00;
    end else if (start) begin
      dmem_req_o   <= 1'b1;
      dmem_we_o    <= mem_write_m_i;
      dmem_addr_o  <= {alu_result_m_i[ADDRESS_WIDTH-1:2], 2'b00};
      dmem_wdata_o <= wdata_d;
      dmem_be_o    <= be_d;
      size_q       <= size;
      unsigned_q   <= funct3_m_i[2];
      lo_q         <= addr_lo;
    end else if ((state_q == REQ) && dmem_ack_i) begin
      dmem_req_o   <= 1'b0;
    end
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    load_byte = dmem_rdata_i[7:0];
    case (lo_q)
      2'b00:   load_byte = dmem_rdata_i[7:0];
      2'b01:   load_byte = dmem_rdata_i[15:8];
      2'b10:   load_byte = dmem_rdata_i[23:16];
      default: load_byte = dmem_rdata_i[31:24];
    endcase
    load_half = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{load_byte[7] & ~unsigned_q}}, load_byte};
      2'b01:   load_ext = {{16{load_half[15] & ~unsigned_q}}, load_half};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  // Load result register: written only by a load ack while a request is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           read_data_m_o <= '0;
    else if ((state_q == REQ) && dmem_ack_i && !dmem_we_o) read_data_m_o <= load_ext;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_m_i;
  logic        mem_write_m_i;
  logic [2:0]  funct3_m_i;
  logic [31:0] alu_result_m_i;
  logic [31:0] write_data_m_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] read_data_m_o;
  logic        stall_m_o;
  logic        misaligned_m_o;

  int tests = 0;
  int fails = 0;

  // Values observed during one transaction
  logic [31:0] o_addr, o_wdata, o_rd_done;
  logic [3:0]  o_be;
  logic        o_we, o_stall_done;
  int          o_stall_n, o_req_n;

  mem_stage_lsu #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_m_i   (mem_read_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .funct3_m_i     (funct3_m_i),
    .alu_result_m_i (alu_result_m_i),
    .write_data_m_i (write_data_m_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .read_data_m_o  (read_data_m_o),
    .stall_m_o      (stall_m_o),
    .misaligned_m_o (misaligned_m_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_m_i   = 1'b0;
    mem_write_m_i  = 1'b0;
    funct3_m_i     = 3'b000;
    alu_result_m_i = 32'h0;
    write_data_m_i = 32'h0;
  endtask

  // Present one access in IDLE, ack it after 'delay' extra REQ cycles, follow it through DONE.
  // Called and returns at 1 time unit after a rising edge, with the FSM in IDLE.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rdata);
    mem_read_m_i   = rd;
    mem_write_m_i  = wr;
    funct3_m_i     = f3;
    alu_result_m_i = addr;
    write_data_m_i = wd;
    o_stall_n = 0;
    o_req_n   = 0;
    #1;
    if (stall_m_o) o_stall_n++;
    if (dmem_req_o) o_req_n++;
    @(posedge clk); #1;
    o_addr  = dmem_addr_o;
    o_be    = dmem_be_o;
    o_wdata = dmem_wdata_o;
    o_we    = dmem_we_o;
    for (int i = 0; i < delay; i++) begin
      if (stall_m_o) o_stall_n++;
      if (dmem_req_o) o_req_n++;
      @(posedge clk); #1;
    end
    if (stall_m_o) o_stall_n++;
    if (dmem_req_o) o_req_n++;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = rdata;
    @(posedge clk); #1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    #1;
    o_stall_done = stall_m_o;
    if (stall_m_o) o_stall_n++;
    if (dmem_req_o) o_req_n++;
    o_rd_done = read_data_m_o;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst_n        = 1'b0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req",   {31'b0, dmem_req_o}, 32'h0);
    chk("reset_we",    {31'b0, dmem_we_o}, 32'h0);
    chk("reset_addr",  dmem_addr_o, 32'h0);
    chk("reset_wdata", dmem_wdata_o, 32'h0);
    chk("reset_be",    {28'b0, dmem_be_o}, 32'h0);
    chk("reset_rdata", read_data_m_o, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory instruction: no stall, no request
    alu_result_m_i = 32'h0000_0104;
    funct3_m_i     = 3'b010;
    #1;
    chk("nonmem_stall", {31'b0, stall_m_o}, 32'h0);
    @(posedge clk); #1;
    chk("nonmem_req", {31'b0, dmem_req_o}, 32'h0);
    idle_inputs();

    // lw 0x100, ack on first REQ cycle
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    chk("lw_addr",       o_addr, 32'h0000_0100);
    chk("lw_be",         {28'b0, o_be}, 32'h0000_000F);
    chk("lw_we",         {31'b0, o_we}, 32'h0);
    chk("lw_stall_cyc",  o_stall_n, 2);
    chk("lw_stall_done", {31'b0, o_stall_done}, 32'h0);
    chk("lw_req_cyc",    o_req_n, 1);
    chk("lw_data_done",  o_rd_done, 32'hDEAD_BEEF);

    // Sub-word loads with sign and zero extension
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    chk("lb_103", o_rd_done, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
    chk("lbu_103", o_rd_done, 32'h0000_0080);
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234);
    chk("lhu_102", o_rd_done, 32'h0000_80FF);
    chk("lhu_be",  {28'b0, o_be}, 32'h0000_000C);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80FF_1234);
    chk("lh_102", o_rd_done, 32'hFFFF_80FF);
    run_op(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 0, 32'h80FF_9234);
    chk("lh_100", o_rd_done, 32'hFFFF_9234);
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0, 0, 32'h80FF_1234);
    chk("lb_101", o_rd_done, 32'h0000_0012);
    chk("lb_be",  {28'b0, o_be}, 32'h0000_0002);

    // sb 0xAB at 0x101, request held 3 cycles, load result untouched
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 2, 32'h5555_5555);
    chk("sb_be",      {28'b0, o_be}, 32'h0000_0002);
    chk("sb_wdata",   o_wdata, 32'hABAB_ABAB);
    chk("sb_we",      {31'b0, o_we}, 32'h1);
    chk("sb_addr",    o_addr, 32'h0000_0100);
    chk("sb_req_cyc", o_req_n, 3);
    chk("sb_rd_keep", read_data_m_o, 32'h0000_0012);

    // sh 0x1234 at 0x102
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_1234, 0, 32'h0);
    chk("sh_be",    {28'b0, o_be}, 32'h0000_000C);
    chk("sh_wdata", o_wdata, 32'h1234_1234);

    // sw with both read and write high: store wins
    run_op(1'b1, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 0, 32'h7777_7777);
    chk("sw_be",      {28'b0, o_be}, 32'h0000_000F);
    chk("sw_wdata",   o_wdata, 32'hCAFE_F00D);
    chk("sw_addr",    o_addr, 32'h0000_0204);
    chk("sw_we",      {31'b0, o_we}, 32'h1);
    chk("sw_rd_keep", read_data_m_o, 32'h0000_0012);

    // lw at 0x102
    mem_read_m_i   = 1'b1;
    funct3_m_i     = 3'b010;
    alu_result_m_i = 32'h0000_0102;
    #1;
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_flag",  {31'b0, misaligned_m_o}, 32'h1);
    chk("mis_stall", {31'b0, stall_m_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mis_noreq", {31'b0, dmem_req_o}, 32'h0);
      chk("mis_hold",  {31'b0, misaligned_m_o}, 32'h1);
    end
    idle_inputs();
`else
    chk("mis_flag", {31'b0, misaligned_m_o}, 32'h0);
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 32'h1122_3344);
    chk("mis_addr", o_addr, 32'h0000_0100);
    chk("mis_be",   {28'b0, o_be}, 32'h0000_000F);
    chk("mis_data", o_rd_done, 32'h1122_3344);
`endif

    // Reset pulsed while a request is outstanding
    mem_read_m_i   = 1'b1;
    funct3_m_i     = 3'b010;
    alu_result_m_i = 32'h0000_0300;
    @(posedge clk); #1;
    chk("rst_pre_req", {31'b0, dmem_req_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",   {31'b0, dmem_req_o}, 32'h0);
    chk("rst_addr",  dmem_addr_o, 32'h0);
    chk("rst_be",    {28'b0, dmem_be_o}, 32'h0);
    chk("rst_rdata", read_data_m_o, 32'h0);
    idle_inputs();
    #1 rst_n = 1'b1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    @(posedge clk); #1;
    chk("late_ack_rdata", read_data_m_o, 32'h0);
    chk("late_ack_req",   {31'b0, dmem_req_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
